// File: rtl/game_pkg.sv
// Shared game-flow types and constants for the controller and the screen renderers.
package game_pkg;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_GAME  = 2'd1,
    ST_OVER  = 2'd2
  } state_e;

  localparam int SCORE_MAX = 999;

endpackage

// File: rtl/click_filter.sv
// Turns the raw left-button level into a one-cycle click pulse.
// Optional debounce of the raw level is enabled by GAME_CLICK_DEBOUNCE_EN.
module click_filter #(
  parameter int DEBOUNCE_CYCLES = 650_000
) (
  input  logic clk,
  input  logic rst,
  input  logic mouse_left,
  output logic click
);

  logic btn_f;
  logic btn_q;

`ifdef GAME_CLICK_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] stable_cnt;
  logic          btn_level;

  // The filtered level flips on the cycle the run of changed raw samples reaches DEBOUNCE_CYCLES.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_level  <= 1'b0;
      stable_cnt <= '0;
    end else if (mouse_left == btn_level) begin
      stable_cnt <= '0;
    end else if (stable_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      btn_level  <= mouse_left;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + CW'(1);
    end
  end

  assign btn_f = btn_level;
`else
  logic unused_debounce;
  assign unused_debounce = (DEBOUNCE_CYCLES != 0);
  assign btn_f = mouse_left;
`endif

  always_ff @(posedge clk) begin
    if (rst) btn_q <= 1'b0;
    else     btn_q <= btn_f;
  end

  assign click = btn_f & ~btn_q;

endmodule

// File: rtl/game_ctrl.sv
// START / GAME / OVER flow controller with click hold-off and score/best tracking.
// Build with GAME_CLICK_DEBOUNCE_EN to debounce the mouse button before edge detection.
module game_ctrl
  import game_pkg::*;
#(
  parameter int HOLDOFF_CYCLES  = 65_000_000,
  parameter int DEBOUNCE_CYCLES = 650_000,
  parameter int SCORE_W         = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mouse_left,
  input  logic               collision,
  input  logic               pipe_hit,
  input  logic               pipe_passed,
  output logic               game_rst,
  output logic               mouse_left_game,
  output state_e             state,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] best_score
);

  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

  state_e             next_state;
  logic               click;
  logic               hit;
  logic               holdoff_done;
  logic               game_rst_d;
  logic               pulse_d;
  logic [HW-1:0]      holdoff_cnt;
  logic [SCORE_W-1:0] score_inc;

  click_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_click_filter (
    .clk       (clk),
    .rst       (rst),
    .mouse_left(mouse_left),
    .click     (click)
  );

  assign hit          = collision | pipe_hit;
  assign holdoff_done = (holdoff_cnt == HW'(HOLDOFF_CYCLES));
  assign score_inc    = (pipe_passed && (score < SCORE_W'(SCORE_MAX))) ? score + SCORE_W'(1) : score;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_START;
    else     state <= next_state;
  end

  // The unused encoding falls through to START so a corrupted register recovers in one cycle.
  always_comb begin
    next_state = ST_START;
    case (state)
      ST_START: next_state = click ? ST_GAME : ST_START;
      ST_GAME:  next_state = hit ? ST_OVER : ST_GAME;
      ST_OVER:  next_state = (click && holdoff_done) ? ST_START : ST_OVER;
      default:  next_state = ST_START;
    endcase
  end

  // A hit in the same cycle as a click suppresses the flap.
  always_comb begin
    game_rst_d = (next_state == ST_START);
    pulse_d    = click && ((state == ST_START) || ((state == ST_GAME) && !hit));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      game_rst        <= 1'b1;
      mouse_left_game <= 1'b0;
    end else begin
      game_rst        <= game_rst_d;
      mouse_left_game <= pulse_d;
    end
  end

  // Best score compares against the final score including a point scored on the hit cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      holdoff_cnt <= '0;
      score       <= '0;
      best_score  <= '0;
    end else begin
      case (state)
        ST_GAME: begin
          score <= score_inc;
          if (hit) begin
            holdoff_cnt <= '0;
            if (score_inc > best_score) best_score <= score_inc;
          end
        end
        ST_OVER: begin
          if (!holdoff_done) holdoff_cnt <= holdoff_cnt + HW'(1);
          if (next_state == ST_START) score <= '0;
        end
        default: score <= '0;
      endcase
    end
  end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Top-level game flow controller for the flappy-bird design. Turns the raw left-button level from the mouse interface into one-cycle click pulses. It owns the START / GAME / OVER state machine and drives `game_rst` and `mouse_left_game` into the bird physics block. It consumes `collision` and pipe events to end the game and keep the current and best score.

## Interface
- `HOLDOFF_CYCLES`, default 65_000_000 — cycles after entering OVER during which clicks are ignored.
- `DEBOUNCE_CYCLES`, default 650_000 — stable-level cycles required by the click filter (used only with the debounce macro).
- `SCORE_W`, default 10 — score counter width; `SCORE_MAX` = 999.
- `clk` in 1 — system clock, single domain.
- `rst` in 1 — synchronous, active-high reset.
- `mouse_left` in 1 — raw left-button level, already synchronous to `clk`.
- `collision` in 1 — level from bird physics (top/bottom hit).
- `pipe_hit` in 1 — level from pipe collision checker.
- `pipe_passed` in 1 — one-cycle pulse when the bird clears a pipe.
- `game_rst` out 1 — held high while in START; resets bird physics.
- `mouse_left_game` out 1 — one-cycle click pulse, only generated in GAME and on the START→GAME transition.
- `state` out 2 — current state (`game_pkg::state_e`).
- `score` out SCORE_W — current game score.
- `best_score` out SCORE_W — highest score since `rst`.

## Operation
- The click filter registers `mouse_left` into `btn_q`. `click = btn_f & ~btn_q` on the filtered level `btn_f`, which equals the raw level when debounce is off.
- States: START (2'd0), GAME (2'd1), OVER (2'd2). 2'd3 is illegal and decodes to START on the next cycle.
- START:
  - `game_rst`=1, `score` held at 0.
  - `click` → GAME. On the next cycle `game_rst`=0 and `mouse_left_game`=1 for exactly one cycle. This gives the bird its first flap.
- GAME:
  - `click` → `mouse_left_game`=1 on the next cycle.
  - `pipe_passed` → `score`+1, saturating at 999.
  - `collision | pipe_hit` → OVER.
  - If `click` and a hit occur in the same cycle, the hit wins: no pulse is generated.
  - If `pipe_passed` and a hit occur in the same cycle, the point is counted.
- Entering OVER:
  - The hold-off counter clears to 0.
  - `best_score` ← max(`best_score`, final `score`), comparison is unsigned.
- OVER:
  - `score` is frozen. The counter increments until it reaches `HOLDOFF_CYCLES`, then holds.
  - `click` while counter < `HOLDOFF_CYCLES` is discarded and never queued.
  - `click` with counter == `HOLDOFF_CYCLES` → START.
  - `score` clears to 0 when START is entered.
- `collision` and `pipe_hit` are ignored in START and OVER.

## Timing
- All outputs are registered.
- Reset values: `state`=START, `game_rst`=1, `mouse_left_game`=0, `score`=0, `best_score`=0, hold-off counter 0, `btn_q`=0.
- Latency without debounce:
  - `mouse_left` 0→1 at cycle N → `click` at N.
  - State or `mouse_left_game` updates at N+1.
- Latency with debounce: the filtered level changes after `DEBOUNCE_CYCLES` consecutive cycles of a changed raw level, so the pulse lands at N+`DEBOUNCE_CYCLES`+1.
- A held button gives exactly one pulse. A new pulse requires a release and a fresh press.
- A hit at cycle N → `state`=OVER at N+1. `best_score` updates at N+1.
- `rst` mid-game returns every register to its reset value on the next edge. `best_score` is cleared too.

## Configuration
- Macro `GAME_CLICK_DEBOUNCE_EN`.
- Defined: the click filter contains a counter of width $clog2(DEBOUNCE_CYCLES+1). The counter resets whenever the raw level equals `btn_f`. `btn_f` toggles when the counter reaches `DEBOUNCE_CYCLES`. Glitches shorter than `DEBOUNCE_CYCLES` produce no click.
- Undefined: `btn_f` = `mouse_left`. The counter logic is absent and `DEBOUNCE_CYCLES` is unused.

## Structure
- `game_pkg` holds:
  - `typedef enum logic [1:0] state_e {ST_START, ST_GAME, ST_OVER}`
  - `localparam SCORE_MAX = 999`
- `game_pkg` is shared with renderers that select screen content by `state`.
- Sub-module `click_filter`: `clk`, `rst`, `mouse_left` → `click` pulse. It contains the optional debounce and the edge detector.
- `game_ctrl` holds the FSM, hold-off counter, and score/best registers.

## Test plan
All scenarios use `HOLDOFF_CYCLES`=20 and `DEBOUNCE_CYCLES`=4.
- **Reset then first click.** Release `rst`, then raise `mouse_left` at cycle 10 with no debounce. Expect `game_rst`=1 through cycle 10. At cycle 11: `state`=GAME, `game_rst`=0, `mouse_left_game`=1. At cycle 12: `mouse_left_game`=0.
- **Held button.** Hold `mouse_left` high for 50 cycles in GAME. Expect exactly one `mouse_left_game` pulse.
- **Collision and click together.** Assert `collision` and a click edge in the same cycle. Expect `state`=OVER next cycle and no pulse.
- **Score and best score.** Send 5 `pipe_passed` pulses, then `pipe_hit`. Expect `score`=5 and `best_score`=5. Play a second game of 3 points: `best_score` stays 5 and `score` is 0 on re-entry to START. Then preload 999: a further `pipe_passed` keeps `score`=999.
- **Hold-off.** Click 10 cycles into OVER: expect `state` unchanged. Click at 25 cycles: expect `state`=START and `game_rst`=1 next cycle.
- **Debounce (macro defined).** Send a 3-cycle high glitch: expect no click. Hold high for 4 cycles: expect the pulse 5 cycles after the rise.
